menu_controller: RTL

Screen-flow controller for the game UI. It decodes mouse clicks on the on-screen buttons (title, success, fail, staff and help screens) and game-result pulses into the screen `state` and `play_valid` unlock mask. The drawing block consumes both to render the screen. It sits between the mouse front end / game logic and the UI renderer.

---
 rtl/ui_pkg.sv | 65 ++++++
 rtl/menu_controller_if.sv | 23 ++
 rtl/ui_button_hit.sv | 16 +
 rtl/menu_controller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared UI definitions: screen state encodings, click task codes and button
// rectangles in 320x240 grid units. The renderer uses the same values.
package ui_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8,
        ST_HELP     = 4'd9
    } ui_state_t;

    typedef enum logic [2:0] {
        TASK_NONE,
        TASK_SEL1,
        TASK_SEL2,
        TASK_SEL3,
        TASK_HELP,
        TASK_NEXT,
        TASK_BACK,
        TASK_RETRY
    } ui_task_t;

    // All buttons share one column; rows are inclusive-low, exclusive-high
    localparam logic [9:0] BTN_X_LO       = 10'd120;
    localparam logic [9:0] BTN_X_HI       = 10'd200;
    localparam logic [9:0] BTN_Y_TOP_LO   = 10'd120;
    localparam logic [9:0] BTN_Y_TOP_HI   = 10'd140;
    localparam logic [9:0] BTN_Y_NEXT_LO  = 10'd140;
    localparam logic [9:0] BTN_Y_NEXT_HI  = 10'd160;
    localparam logic [9:0] BTN_Y_MID_LO   = 10'd150;
    localparam logic [9:0] BTN_Y_MID_HI   = 10'd170;
    localparam logic [9:0] BTN_Y_LOW_LO   = 10'd180;
    localparam logic [9:0] BTN_Y_LOW_HI   = 10'd200;
    localparam logic [9:0] BTN_Y_HBACK_LO = 10'd200;
    localparam logic [9:0] BTN_Y_HBACK_HI = 10'd220;
    localparam logic [9:0] BTN_Y_HELP_LO  = 10'd210;
    localparam logic [9:0] BTN_Y_HELP_HI  = 10'd230;

    function automatic logic is_stage(ui_state_t s);
        return s inside {ST_STAGE1, ST_STAGE2, ST_STAGE3};
    endfunction

    function automatic logic [1:0] stage_num(ui_state_t s);
        case (s)
            ST_STAGE2: return 2'd2;
            ST_STAGE3: return 2'd3;
            default:   return 2'd1;
        endcase
    endfunction

    function automatic ui_state_t stage_state(logic [1:0] n);
        case (n)
            2'd2:    return ST_STAGE2;
            2'd3:    return ST_STAGE3;
            default: return ST_STAGE1;
        endcase
    endfunction

endpackage

// File: rtl/menu_controller_if.sv
// Mouse/game-result inputs and screen-state outputs of menu_controller.
// master drives the inputs and observes the screen state; slave is the controller.
interface menu_controller_if;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       click;
    logic       stage_clear;
    logic       stage_fail;
    logic [3:0] state;
    logic [3:0] play_valid;
    logic       stage_start;
    logic [1:0] cur_stage;

    modport master (
        output mouse_x, mouse_y, click, stage_clear, stage_fail,
        input  state, play_valid, stage_start, cur_stage
    );

    modport slave (
        input  mouse_x, mouse_y, click, stage_clear, stage_fail,
        output state, play_valid, stage_start, cur_stage
    );
endinterface

// File: rtl/ui_button_hit.sv
// Combinational test of a grid point against one button rectangle, gated by en.
module ui_button_hit #(
    parameter logic [9:0] X_LO = 10'd0,
    parameter logic [9:0] X_HI = 10'd1,
    parameter logic [9:0] Y_LO = 10'd0,
    parameter logic [9:0] Y_HI = 10'd1
) (
    input  logic [9:0] gx,
    input  logic [9:0] gy,
    input  logic       en,
    output logic       hit
);
    always_comb begin
        hit = en && (gx >= X_LO) && (gx < X_HI) && (gy >= Y_LO) && (gy < Y_HI);
    end
endmodule

// File: rtl/menu_controller.sv
// Screen-flow FSM: decodes button clicks and stage results into screen state
// and the stage unlock mask. Define MENU_UNLOCK_ALL_EN to unlock all stages at reset.
module menu_controller #(
    parameter int unsigned SCALE_SHIFT = 1
) (
    input logic               clk,
    input logic               rst,
    menu_controller_if.slave  bus
);
    import ui_pkg::*;

`ifdef MENU_UNLOCK_ALL_EN
    localparam logic [3:0] PV_RESET = 4'b1110;
`else
    localparam logic [3:0] PV_RESET = 4'b0010;
`endif

    ui_state_t  state_q, state_d;
    logic [3:0] pv_q, pv_d;
    logic [1:0] cur_q, cur_d;
    logic       ss_q, ss_d;
    logic       click_q;
    ui_task_t   click_task;

    logic [9:0] gx, gy;
    logic       in_range, click_en;
    logic       hit_top, hit_next, hit_mid, hit_low, hit_hback, hit_help;

    always_comb begin
        gx       = bus.mouse_x >> SCALE_SHIFT;
        gy       = bus.mouse_y >> SCALE_SHIFT;
        in_range = (bus.mouse_x < 10'd640) && (bus.mouse_y < 10'd480);
        click_en = bus.click && !click_q && in_range;
    end

    ui_button_hit #(.X_LO(BTN_X_LO), .X_HI(BTN_X_HI), .Y_LO(BTN_Y_TOP_LO), .Y_HI(BTN_Y_TOP_HI))
        u_hit_top   (.gx(gx), .gy(gy), .en(click_en), .hit(hit_top));
    ui_button_hit #(.X_LO(BTN_X_LO), .X_HI(BTN_X_HI), .Y_LO(BTN_Y_NEXT_LO), .Y_HI(BTN_Y_NEXT_HI))
        u_hit_next  (.gx(gx), .gy(gy), .en(click_en), .hit(hit_next));
    ui_button_hit #(.X_LO(BTN_X_LO), .X_HI(BTN_X_HI), .Y_LO(BTN_Y_MID_LO), .Y_HI(BTN_Y_MID_HI))
        u_hit_mid   (.gx(gx), .gy(gy), .en(click_en), .hit(hit_mid));
    ui_button_hit #(.X_LO(BTN_X_LO), .X_HI(BTN_X_HI), .Y_LO(BTN_Y_LOW_LO), .Y_HI(BTN_Y_LOW_HI))
        u_hit_low   (.gx(gx), .gy(gy), .en(click_en), .hit(hit_low));
    ui_button_hit #(.X_LO(BTN_X_LO), .X_HI(BTN_X_HI), .Y_LO(BTN_Y_HBACK_LO), .Y_HI(BTN_Y_HBACK_HI))
        u_hit_hback (.gx(gx), .gy(gy), .en(click_en), .hit(hit_hback));
    ui_button_hit #(.X_LO(BTN_X_LO), .X_HI(BTN_X_HI), .Y_LO(BTN_Y_HELP_LO), .Y_HI(BTN_Y_HELP_HI))
        u_hit_help  (.gx(gx), .gy(gy), .en(click_en), .hit(hit_help));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_TITLE;
            pv_q    <= PV_RESET;
            cur_q   <= 2'd1;
            ss_q    <= 1'b0;
            click_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pv_q    <= pv_d;
            cur_q   <= cur_d;
            ss_q    <= ss_d;
            click_q <= bus.click;
        end
    end

    // Map the rectangle hits that are live on the current screen to an action
    always_comb begin
        click_task = TASK_NONE;
        case (state_q)
            ST_TITLE: begin
                if (hit_top)                 click_task = TASK_SEL1;
                else if (hit_mid && pv_q[2]) click_task = TASK_SEL2;
                else if (hit_low && pv_q[3]) click_task = TASK_SEL3;
                else if (hit_help)           click_task = TASK_HELP;
            end
            ST_SUCCESS1, ST_SUCCESS2: begin
                if (hit_next)     click_task = TASK_NEXT;
                else if (hit_low) click_task = TASK_BACK;
            end
            ST_SUCCESS3: if (hit_mid) click_task = TASK_NEXT;
            ST_FAIL: begin
                if (hit_next)     click_task = TASK_RETRY;
                else if (hit_low) click_task = TASK_BACK;
            end
            ST_STAFF: if (hit_low)   click_task = TASK_BACK;
            ST_HELP:  if (hit_hback) click_task = TASK_BACK;
            default:  click_task = TASK_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pv_d    = pv_q;
        case (click_task)
            TASK_SEL1:  state_d = ST_STAGE1;
            TASK_SEL2:  state_d = ST_STAGE2;
            TASK_SEL3:  state_d = ST_STAGE3;
            TASK_HELP:  state_d = ST_HELP;
            TASK_BACK:  state_d = ST_TITLE;
            TASK_RETRY: state_d = stage_state(cur_q);
            TASK_NEXT: begin
                case (state_q)
                    ST_SUCCESS1: state_d = ST_STAGE2;
                    ST_SUCCESS2: state_d = ST_STAGE3;
                    ST_SUCCESS3: state_d = ST_STAFF;
                    default:     state_d = state_q;
                endcase
            end
            default: begin
                // Clear takes priority over fail when both pulse together
                case (state_q)
                    ST_STAGE1: begin
                        if (bus.stage_clear) begin
                            state_d = ST_SUCCESS1;
                            pv_d[2] = 1'b1;
                        end else if (bus.stage_fail) begin
                            state_d = ST_FAIL;
                        end
                    end
                    ST_STAGE2: begin
                        if (bus.stage_clear) begin
                            state_d = ST_SUCCESS2;
                            pv_d[3] = 1'b1;
                        end else if (bus.stage_fail) begin
                            state_d = ST_FAIL;
                        end
                    end
                    ST_STAGE3: begin
                        if (bus.stage_clear)     state_d = ST_SUCCESS3;
                        else if (bus.stage_fail) state_d = ST_FAIL;
                    end
                    default: state_d = state_q;
                endcase
            end
        endcase
        ss_d  = is_stage(state_d) && (state_d != state_q);
        cur_d = is_stage(state_d) ? stage_num(state_d) : cur_q;
    end

    always_comb begin
        bus.state       = state_q;
        bus.play_valid  = pv_q;
        bus.cur_stage   = cur_q;
        bus.stage_start = ss_q;
    end

endmodule
